// File: rtl/l1a_mailbox_pkg.sv
// Shared definitions for the BBC host mailbox.
// Holds the register offsets inside the 4-byte host window, the STATUS and
// CTRL bit positions, the value returned for empty/unused reads and a helper
// that assembles the STATUS byte.
package l1a_mailbox_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_DATA   = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_NOTFULL  = 1;
  localparam int ST_TX_OVERFLOW = 2;
  localparam int ST_IRQ_PENDING = 7;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_TX_FLUSH = 1;

  localparam logic [7:0] EMPTY_READ = 8'h00;

  function automatic logic [7:0] status_byte(input logic rx_nonempty,
                                             input logic tx_notfull,
                                             input logic tx_overflow,
                                             input logic irq_pending);
    logic [7:0] s;
    s                 = 8'h00;
    s[ST_RX_NONEMPTY] = rx_nonempty;
    s[ST_TX_NOTFULL]  = tx_notfull;
    s[ST_TX_OVERFLOW] = tx_overflow;
    s[ST_IRQ_PENDING] = irq_pending;
    return s;
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic irq_en);
    logic [7:0] c;
    c              = 8'h00;
    c[CTRL_IRQ_EN] = irq_en;
    return c;
  endfunction

endpackage

// File: rtl/l1a_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (pointers/count)
//   push, push_data  write request; refused when full at start of cycle
//   pop              read request; ignored when empty
//   flush            empties the FIFO; overrides push and pop that cycle
//   head             oldest entry, valid whenever empty is low
//   full, empty      occupancy flags
//   count            number of stored entries (clog2(DEPTH)+1 bits)
module l1a_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // Flags are those at the start of the cycle, so a push into a full FIFO is
  // refused even when a pop frees a slot on the same edge.
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bbc_host_mailbox.sv
// BBC host-bus mailbox: a 4-byte register window on the 6502-style host bus
// bridging two byte FIFOs to an accelerator stream interface.
// Ports:
//   bbc_ck8, rst              8 MHz clock, asynchronous active-high reset
//   phi0                      host bus phase (2 cycles high, 2 low)
//   bbc_addr, bbc_rdnw        host address and direction, sampled at phi0 rise
//   bbc_data_in               host write data, captured while phi0 high
//   bbc_data_out, bbc_data_oe host read data and its drive enable
//   irqb                      active-low interrupt (irq_en & rx_nonempty)
//   tx_data/valid/ready       host-written bytes toward the accelerator
//   rx_data/valid/ready       accelerator bytes readable by the host
module bbc_host_mailbox
  import l1a_mailbox_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFEE0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        bbc_ck8,
  input  logic        rst,
  input  logic        phi0,
  input  logic [15:0] bbc_addr,
  input  logic        bbc_rdnw,
  input  logic [7:0]  bbc_data_in,
  output logic [7:0]  bbc_data_out,
  output logic        bbc_data_oe,
  output logic        irqb,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             phi0_q;
  logic             armed;
  logic             active;
  reg_off_e         acc_off;
  logic             acc_rdnw;
  logic [7:0]       wdata;
  logic             irq_en;
  logic             tx_overflow;

  logic             rise;
  logic             fall;
  logic             addr_hit;
  logic             commit;
  logic [7:0]       rd_val;

  logic [7:0]       rx_head;
  logic             rx_full;
  logic             rx_empty;
  logic [CNT_W-1:0] rx_count;
  logic             tx_full;
  logic             tx_empty;
  logic [CNT_W-1:0] tx_count;

  logic             rx_nonempty;
  logic             tx_notfull;
  logic             irq_pending;
  logic             host_pop;
  logic             host_push;
  logic             ctrl_wr;
  logic             tx_flush;
  logic             status_rd;
  logic             ovf_set;
  logic             tx_pop;

  // armed stays low after reset until phi0 has been seen low, so a phase
  // already high at reset release is not mistaken for a fresh rise.
  assign rise     = phi0 & ~phi0_q & armed;
  assign fall     = ~phi0 & phi0_q;
  assign addr_hit = rise & (bbc_addr[15:2] == BASE_ADDR[15:2]);
  assign commit   = fall & active;

  assign rx_nonempty = (rx_count != '0);
  assign tx_notfull  = (tx_count != CNT_W'(FIFO_DEPTH));
  assign irq_pending = irq_en & rx_nonempty;

  assign host_pop  = commit &  acc_rdnw & (acc_off == REG_DATA);
  assign host_push = commit & ~acc_rdnw & (acc_off == REG_DATA);
  assign ctrl_wr   = commit & ~acc_rdnw & (acc_off == REG_CTRL);
  assign status_rd = commit &  acc_rdnw & (acc_off == REG_STATUS);
  assign tx_flush  = ctrl_wr & wdata[CTRL_TX_FLUSH];
  assign ovf_set   = host_push & tx_full;

  assign rx_ready = ~rx_full;
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  // Read value is chosen from state at the rise cycle; a pop committed later
  // in the same access does not disturb the byte already presented.
  always_comb begin
    rd_val = EMPTY_READ;
    case (reg_off_e'(bbc_addr[1:0]))
      REG_STATUS: rd_val = status_byte(rx_nonempty, tx_notfull, tx_overflow, irq_pending);
      REG_DATA:   rd_val = rx_empty ? EMPTY_READ : rx_head;
      REG_CTRL:   rd_val = ctrl_byte(irq_en);
      default:    rd_val = EMPTY_READ;
    endcase
  end

  // Bus phase tracking, access decode and register commit
  always_ff @(posedge bbc_ck8 or posedge rst) begin
    if (rst) begin
      phi0_q       <= 1'b0;
      armed        <= 1'b0;
      active       <= 1'b0;
      acc_off      <= REG_STATUS;
      acc_rdnw     <= 1'b1;
      irq_en       <= 1'b0;
      tx_overflow  <= 1'b0;
      bbc_data_out <= EMPTY_READ;
      bbc_data_oe  <= 1'b0;
      irqb         <= 1'b1;
    end else begin
      phi0_q <= phi0;
      armed  <= armed | ~phi0;

      if (rise) begin
        active <= addr_hit;
        if (addr_hit) begin
          acc_off  <= reg_off_e'(bbc_addr[1:0]);
          acc_rdnw <= bbc_rdnw;
          if (bbc_rdnw) begin
            bbc_data_out <= rd_val;
            bbc_data_oe  <= 1'b1;
          end
        end
      end else if (fall) begin
        active      <= 1'b0;
        bbc_data_oe <= 1'b0;
      end

      if (ctrl_wr) irq_en <= wdata[CTRL_IRQ_EN];

      // A new overflow wins over the clear-on-read.
      if (ovf_set)        tx_overflow <= 1'b1;
      else if (status_rd) tx_overflow <= 1'b0;

      irqb <= ~irq_pending;
    end
  end

  // Write data follows the bus while phi0 is high; the last value captured
  // before the fall is the one committed.
  always_ff @(posedge bbc_ck8) begin
    if (phi0 & ((addr_hit & ~bbc_rdnw) | (active & ~acc_rdnw)))
      wdata <= bbc_data_in;
  end

  l1a_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (bbc_ck8),
    .rst       (rst),
    .push      (rx_valid & rx_ready),
    .push_data (rx_data),
    .pop       (host_pop),
    .flush     (1'b0),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  l1a_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (bbc_ck8),
    .rst       (rst),
    .push      (host_push),
    .push_data (wdata),
    .pop       (tx_pop),
    .flush     (tx_flush),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

endmodule

// File: tb/tb_bbc_host_mailbox.sv
// Directed bench for bbc_host_mailbox: host bus accesses built from phi0
// phases, stream-side pushes/pops, and hand-computed expected bytes.
module tb_bbc_host_mailbox;

  logic        bbc_ck8;
  logic        rst;
  logic        phi0;
  logic [15:0] bbc_addr;
  logic        bbc_rdnw;
  logic [7:0]  bbc_data_in;
  logic [7:0]  bbc_data_out;
  logic        bbc_data_oe;
  logic        irqb;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  bbc_host_mailbox #(
    .BASE_ADDR  (16'hFEE0),
    .FIFO_DEPTH (8)
  ) dut (
    .bbc_ck8      (bbc_ck8),
    .rst          (rst),
    .phi0         (phi0),
    .bbc_addr     (bbc_addr),
    .bbc_rdnw     (bbc_rdnw),
    .bbc_data_in  (bbc_data_in),
    .bbc_data_out (bbc_data_out),
    .bbc_data_oe  (bbc_data_oe),
    .irqb         (irqb),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  initial bbc_ck8 = 1'b0;
  always #5 bbc_ck8 = ~bbc_ck8;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bbc_ck8);
    #1;
  endtask

  // One full host bus cycle: two phi0-low cycles with address set up, two
  // phi0-high cycles, then the fall cycle. Returns the read byte and oe as
  // seen right after the rise edge, and can offer an rx byte on the fall cycle.
  task automatic host_access(input logic [15:0] a, input logic rd, input logic [7:0] d,
                             input logic rx_at_fall, input logic [7:0] rx_b,
                             output logic [7:0] q, output logic oe_mid);
    bbc_addr    = a;
    bbc_rdnw    = rd;
    bbc_data_in = d;
    phi0        = 1'b0;
    step();
    step();
    phi0 = 1'b1;
    step();
    q      = bbc_data_out;
    oe_mid = bbc_data_oe;
    step();
    phi0 = 1'b0;
    if (rx_at_fall) begin
      rx_valid = 1'b1;
      rx_data  = rx_b;
    end
    step();
    rx_valid = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [7:0] q, output logic oe_mid);
    host_access(a, 1'b1, 8'h00, 1'b0, 8'h00, q, oe_mid);
  endtask

  task automatic host_write(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] q;
    logic       oe;
    host_access(a, 1'b0, d, 1'b0, 8'h00, q, oe);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] q;
    logic       oe;
    int         n;

    rst = 1'b1; phi0 = 1'b0; bbc_addr = 16'h0000; bbc_rdnw = 1'b1;
    bbc_data_in = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    step(); step(); step();

    check("rst_data_out", bbc_data_out, 8'h00);
    check("rst_oe", {7'd0, bbc_data_oe}, 8'h00);
    check("rst_irqb", {7'd0, irqb}, 8'h01);
    check("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
    check("rst_rx_ready", {7'd0, rx_ready}, 8'h01);
    rst = 1'b0;
    step();

    // Host write reaches the tx stream
    host_write(16'hFEE1, 8'h5A);
    check("tx_valid_after_wr", {7'd0, tx_valid}, 8'h01);
    check("tx_data_after_wr", tx_data, 8'h5A);
    host_read(16'hFEE0, q, oe);
    check("status_one_tx", q, 8'h02);
    check("status_oe_mid", {7'd0, oe}, 8'h01);
    check("oe_after_fall", {7'd0, bbc_data_oe}, 8'h00);
    host_read(16'hFEE3, q, oe);
    check("rsvd_read", q, 8'h00);
    host_read(16'hFEE2, q, oe);
    check("ctrl_reset_read", q, 8'h00);

    // Out-of-window accesses
    host_read(16'hFEE4, q, oe);
    check("oe_fee4", {7'd0, oe}, 8'h00);
    host_read(16'hFEDF, q, oe);
    check("oe_fedf", {7'd0, oe}, 8'h00);
    host_write(16'hFEE5, 8'h77);
    host_write(16'hFEDD, 8'h66);
    host_read(16'hFEE0, q, oe);
    check("status_after_miss", q, 8'h02);
    check("tx_head_after_miss", tx_data, 8'h5A);

    // Flush
    host_write(16'hFEE2, 8'h02);
    check("tx_valid_after_flush", {7'd0, tx_valid}, 8'h00);
    host_read(16'hFEE2, q, oe);
    check("ctrl_flush_selfclr", q, 8'h00);

    // Overflow
    for (int i = 0; i < 9; i++) host_write(16'hFEE1, 8'(i));
    host_read(16'hFEE0, q, oe);
    check("status_overflow", q, 8'h04);
    host_read(16'hFEE0, q, oe);
    check("status_ovf_cleared", q, 8'h00);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {7'd0, tx_valid}, 8'h01);
      check("drain_data", tx_data, 8'(i));
      step();
    end
    tx_ready = 1'b0;
    check("drain_empty", {7'd0, tx_valid}, 8'h00);

    // rx path and interrupt
    rx_push(8'h11);
    rx_push(8'h22);
    host_write(16'hFEE2, 8'h01);
    n = 0;
    while (irqb !== 1'b0 && n < 2) begin
      step();
      n++;
    end
    check("irqb_low", {7'd0, irqb}, 8'h00);
    host_read(16'hFEE0, q, oe);
    check("status_irq", q, 8'h83);
    host_read(16'hFEE1, q, oe);
    check("rx_read_1", q, 8'h11);
    host_read(16'hFEE1, q, oe);
    check("rx_read_2", q, 8'h22);
    step();
    check("irqb_high", {7'd0, irqb}, 8'h01);
    host_read(16'hFEE1, q, oe);
    check("rx_read_empty", q, 8'h00);
    host_read(16'hFEE2, q, oe);
    check("ctrl_irq_en", q, 8'h01);

    // Full rx FIFO: simultaneous pop and push
    for (int i = 0; i < 8; i++) rx_push(8'h30 + 8'(i));
    check("rx_ready_full", {7'd0, rx_ready}, 8'h00);
    host_access(16'hFEE1, 1'b1, 8'h00, 1'b1, 8'h99, q, oe);
    check("full_pop_data", q, 8'h30);
    check("rx_ready_after_pop", {7'd0, rx_ready}, 8'h01);
    for (int i = 1; i < 8; i++) begin
      host_read(16'hFEE1, q, oe);
      check("rx_drain", q, 8'h30 + 8'(i));
    end
    host_read(16'hFEE1, q, oe);
    check("rx_push_refused", q, 8'h00);

    // Reset in the middle of a DATA read
    rx_push(8'h41);
    rx_push(8'h42);
    rx_push(8'h43);
    bbc_addr = 16'hFEE1; bbc_rdnw = 1'b1; phi0 = 1'b0;
    step();
    step();
    phi0 = 1'b1;
    step();
    check("abort_oe_before", {7'd0, bbc_data_oe}, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("abort_oe", {7'd0, bbc_data_oe}, 8'h00);
    check("abort_data_out", bbc_data_out, 8'h00);
    check("abort_irqb", {7'd0, irqb}, 8'h01);
    check("abort_rx_ready", {7'd0, rx_ready}, 8'h01);
    @(posedge bbc_ck8);
    #1;
    rst = 1'b0;
    step();
    check("no_rise_after_rst", {7'd0, bbc_data_oe}, 8'h00);
    phi0 = 1'b0;
    step();
    step();
    host_read(16'hFEE0, q, oe);
    check("status_after_abort", q, 8'h02);
    host_read(16'hFEE1, q, oe);
    check("rx_empty_after_abort", q, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bbc_host_mailbox.md
BBC_HOST_MAILBOX -- requirements
Module: bbc_host_mailbox

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFEE0, host address of the 4-byte register window (bits [1:0] ignored).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per FIFO (power of two, 2..16).
REQ-003 Clocking and reset are fixed: one clock; reset is asynchronous and active-high. The clock port is bbc_ck8 and the reset port is rst.
REQ-004 bbc_ck8  in  1  8 MHz host clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 phi0  in  1  host bus phase; synchronous to bbc_ck8; high 2 cycles (phi2 phase), low 2 cycles.
REQ-007 bbc_addr  in  16  host address, valid before phi0 rises.
REQ-008 bbc_rdnw  in  1  1 = host read, 0 = host write.
REQ-009 bbc_data_in  in  8  host write data, valid while phi0 high.
REQ-010 bbc_data_out  out  8  read data to host bus.
REQ-011 bbc_data_oe  out  1  drive enable for bbc_data_out.
REQ-012 irqb  out  1  active-low host interrupt.
REQ-013 tx_data  out  8, tx_valid  out  1, tx_ready  in  1: host-written bytes toward accelerator.
REQ-014 rx_data  in  8, rx_valid  in  1, rx_ready  out  1: accelerator bytes readable by host.

Function
REQ-015 SHALL register phi0 each cycle (phi0_q); rise = phi0 & ~phi0_q; fall = ~phi0 & phi0_q.
REQ-016 On rise with bbc_addr[15:2] == BASE_ADDR[15:2], SHALL latch offset bbc_addr[1:0] and bbc_rdnw and mark the access active; otherwise no access.
REQ-017 Registers: offset 0 STATUS (R): bit0 rx_nonempty, bit1 tx_notfull, bit2 tx_overflow, bit7 irq_pending, others 0; offset 1 DATA (R pops rx FIFO, W pushes tx FIFO); offset 2 CTRL (R/W) bit0 irq_en, bit1 tx_flush (self-clearing, reads 0); offset 3 reads 0x00, writes ignored.
REQ-018 Read: bbc_data_out SHALL be loaded on the rise cycle, presenting the selected value from the next edge; bbc_data_oe SHALL be high from that edge until the edge after fall, else low.
REQ-019 Write: bbc_data_in SHALL be captured every cycle phi0 is high during an active write; last captured value is committed on fall.
REQ-020 All side effects (pop, push, CTRL update, overflow clear) SHALL occur exactly once, on the fall cycle of an active access.
REQ-021 DATA read with rx FIFO empty SHALL return 0x00 and not pop.
REQ-022 DATA write with tx FIFO full SHALL drop the byte and set tx_overflow; STATUS read clears tx_overflow on fall unless a new overflow occurs that cycle (set wins).
REQ-023 tx_flush SHALL empty tx FIFO on the commit cycle; a simultaneous tx pop is discarded.
REQ-024 Stream sides: rx push when rx_valid & rx_ready, rx_ready = ~rx_full; tx pop when tx_valid & tx_ready, tx_valid = ~tx_empty, tx_data = FIFO head (first-word fall-through).
REQ-025 Simultaneous push and pop on one FIFO SHALL both occur, count unchanged; push to full-at-start-of-cycle refused even if popped that cycle.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-027 irq_pending = irq_en & rx_nonempty; irqb = ~irq_pending, registered (one cycle latency).
REQ-028 Read data latency: value reflects state at rise cycle; pops committed in the same access do not alter the presented byte.

Reset
REQ-029 rst high SHALL immediately force: FIFOs empty, pointers 0, irq_en 0, tx_overflow 0, access inactive, phi0_q 0, bbc_data_out 0x00, bbc_data_oe 0, irqb 1, tx_valid 0, rx_ready 1 after release.
REQ-030 Reset mid-access SHALL abort it with no side effects; first access after release requires a fresh rise.

Structure
REQ-031 Package l1a_mailbox_pkg SHALL hold register offsets, STATUS/CTRL bit positions and the empty-read value.
REQ-032 One sub-module l1a_sync_fifo (parameterised width/depth, fall-through, full/empty/count) SHALL be instantiated twice.

Verification
REQ-033 Write 0x5A to 0xFEE1 with tx_ready=0 -> tx_valid=1, tx_data=0x5A after fall; STATUS reads 0x02 (tx_notfull) bit1 set.
REQ-034 rx push 0x11,0x22; CTRL=0x01 -> irqb low within 2 cycles; two DATA reads return 0x11 then 0x22; irqb high after second fall; third read returns 0x00.
REQ-035 Nine writes 0x00..0x08 to DATA with tx_ready=0 -> STATUS 0x04 set, FIFO holds 0x00..0x07; next STATUS read clears bit2.
REQ-036 Access to 0xFEE4 or 0xFEDF -> bbc_data_oe stays 0, no state change.
REQ-037 rst asserted during phi0 high of a DATA read with rx count 3 -> count 0, oe 0 immediately; no pop after release.
REQ-038 Simultaneous rx push and host DATA pop with count=FIFO_DEPTH -> pop taken, push refused, count=FIFO_DEPTH-1.
